// File: rtl/cmos_pixel_pack.sv
// ============================================================================
// Module   : cmos_pixel_pack
// Purpose  : Packs RATIO consecutive IN_W-bit sensor beats into one word,
//            realigning on every line end and frame sync. Optional macro
//            CMOS_PACK_FLUSH_EN emits a zero-padded partial word at line end.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cmos_pixel_pack #(
  parameter int IN_W      = 8,
  parameter int RATIO     = 2,
  parameter int MSB_FIRST = 1
) (
  input  logic                  pclk,
  input  logic                  rst,
  input  logic                  vsync_i,
  input  logic                  de_i,
  input  logic [IN_W-1:0]       pdata_i,
  output logic [IN_W*RATIO-1:0] pdata_o,
  output logic                  de_o,
  output logic                  eol_o,
  output logic [11:0]           line_words_o
);

  localparam int             OUT_W = IN_W * RATIO;
  localparam int             BW    = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [BW-1:0]  LAST  = BW'(RATIO - 1);

  logic              r_de;
  logic              r_vs;
  logic [IN_W-1:0]   r_data;
  logic [BW-1:0]     r_bcnt;
  logic [OUT_W-1:0]  r_acc;
  logic              r_in_line;
  logic [11:0]       r_wcnt;

  logic [BW-1:0]     w_slot;
  logic [OUT_W-1:0]  w_word;
  logic [11:0]       w_wcnt_inc;

  // Current beat merged into the partial accumulator at its slot.
  always_comb begin
    w_slot = (MSB_FIRST != 0) ? (LAST - r_bcnt) : r_bcnt;
    w_word = r_acc;
    for (int s = 0; s < RATIO; s++) begin
      if (BW'(s) == w_slot) begin
        w_word[s*IN_W +: IN_W] = r_data;
      end
    end
    w_wcnt_inc = (r_wcnt == 12'hFFF) ? r_wcnt : r_wcnt + 12'd1;
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      r_de         <= 1'b0;
      r_vs         <= 1'b0;
      r_data       <= '0;
      r_bcnt       <= '0;
      r_acc        <= '0;
      r_in_line    <= 1'b0;
      r_wcnt       <= '0;
      pdata_o      <= '0;
      de_o         <= 1'b0;
      eol_o        <= 1'b0;
      line_words_o <= '0;
    end else begin
      r_de    <= de_i;
      r_vs    <= vsync_i;
      r_data  <= pdata_i;
      de_o    <= 1'b0;
      pdata_o <= '0;
      eol_o   <= 1'b0;
      if (r_vs) begin
        // Frame sync aborts the line silently: no eol, no flush.
        r_bcnt    <= '0;
        r_acc     <= '0;
        r_wcnt    <= '0;
        r_in_line <= 1'b0;
      end else if (r_de) begin
        r_in_line <= 1'b1;
        if (r_bcnt == LAST) begin
          de_o    <= 1'b1;
          pdata_o <= w_word;
          r_acc   <= '0;
          r_bcnt  <= '0;
          r_wcnt  <= w_wcnt_inc;
        end else begin
          r_acc  <= w_word;
          r_bcnt <= r_bcnt + BW'(1);
        end
      end else if (r_in_line) begin
        eol_o     <= 1'b1;
        r_in_line <= 1'b0;
        r_bcnt    <= '0;
        r_acc     <= '0;
        r_wcnt    <= '0;
`ifdef CMOS_PACK_FLUSH_EN
        if (r_bcnt != '0) begin
          de_o         <= 1'b1;
          pdata_o      <= r_acc;
          line_words_o <= w_wcnt_inc;
        end else begin
          line_words_o <= r_wcnt;
        end
`else
        line_words_o <= r_wcnt;
`endif
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cmos_pixel_pack.sv
// ============================================================================
// Module   : tb_cmos_pixel_pack
// Purpose  : Directed checks of cmos_pixel_pack in three configurations
//            (8x2 MSB-first, 8x4 LSB-first, 8x3 MSB-first).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cmos_pixel_pack;

  logic        pclk = 1'b0;
  logic        rst;
  logic        vsync_i;
  logic        de_i;
  logic [7:0]  pdata_i;

  logic [15:0] a_pdata;
  logic        a_de, a_eol;
  logic [11:0] a_lw;
  logic [31:0] b_pdata;
  logic        b_de, b_eol;
  logic [11:0] b_lw;
  logic [23:0] c_pdata;
  logic        c_de, c_eol;
  logic [11:0] c_lw;

  int checks   = 0;
  int failures = 0;

  always #5 pclk = ~pclk;

  cmos_pixel_pack #(.IN_W(8), .RATIO(2), .MSB_FIRST(1)) u_a (
    .pclk(pclk), .rst(rst), .vsync_i(vsync_i), .de_i(de_i), .pdata_i(pdata_i),
    .pdata_o(a_pdata), .de_o(a_de), .eol_o(a_eol), .line_words_o(a_lw));

  cmos_pixel_pack #(.IN_W(8), .RATIO(4), .MSB_FIRST(0)) u_b (
    .pclk(pclk), .rst(rst), .vsync_i(vsync_i), .de_i(de_i), .pdata_i(pdata_i),
    .pdata_o(b_pdata), .de_o(b_de), .eol_o(b_eol), .line_words_o(b_lw));

  cmos_pixel_pack #(.IN_W(8), .RATIO(3), .MSB_FIRST(1)) u_c (
    .pclk(pclk), .rst(rst), .vsync_i(vsync_i), .de_i(de_i), .pdata_i(pdata_i),
    .pdata_o(c_pdata), .de_o(c_de), .eol_o(c_eol), .line_words_o(c_lw));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, let the edge sample them, observe 1ns later.
  task automatic drive(input logic r, input logic vs, input logic de, input logic [7:0] d);
    rst = r; vsync_i = vs; de_i = de; pdata_i = d;
    @(posedge pclk);
    #1;
  endtask

  initial begin
    rst = 1'b1; vsync_i = 1'b0; de_i = 1'b0; pdata_i = 8'h00;
    #1;
    drive(1, 0, 0, 8'h00);
    drive(1, 0, 0, 8'h00);
    chk("rst_de",    {31'd0, a_de},  32'd0);
    chk("rst_eol",   {31'd0, a_eol}, 32'd0);
    chk("rst_pdata", {16'd0, a_pdata}, 32'd0);
    chk("rst_lw",    {20'd0, a_lw},  32'd0);
    drive(0, 0, 0, 8'h00);
    drive(0, 0, 0, 8'h00);

    // Basic 8->16 MSB-first
    drive(0, 0, 1, 8'h11);
    drive(0, 0, 1, 8'h22);
    chk("basic_idle", {31'd0, a_de}, 32'd0);
    drive(0, 0, 1, 8'h33);
    chk("basic_w0_de", {31'd0, a_de}, 32'd1);
    chk("basic_w0",    {16'd0, a_pdata}, 32'h1122);
    drive(0, 0, 1, 8'h44);
    chk("basic_gap_de", {31'd0, a_de}, 32'd0);
    drive(0, 0, 0, 8'h00);
    chk("basic_w1_de",  {31'd0, a_de}, 32'd1);
    chk("basic_w1",     {16'd0, a_pdata}, 32'h3344);
    chk("basic_no_eol", {31'd0, a_eol}, 32'd0);
    drive(0, 0, 0, 8'h00);
    chk("basic_eol",    {31'd0, a_eol}, 32'd1);
    chk("basic_eol_de", {31'd0, a_de}, 32'd0);
    chk("basic_lw",     {20'd0, a_lw}, 32'd2);
    drive(0, 0, 0, 8'h00);
    chk("basic_eol_1cyc", {31'd0, a_eol}, 32'd0);
    chk("basic_lw_hold",  {20'd0, a_lw}, 32'd2);

    // LSB-first, RATIO=4
    drive(0, 0, 1, 8'h01);
    drive(0, 0, 1, 8'h02);
    drive(0, 0, 1, 8'h03);
    drive(0, 0, 1, 8'h04);
    chk("lsb_pre_de", {31'd0, b_de}, 32'd0);
    drive(0, 0, 0, 8'h00);
    chk("lsb_de",   {31'd0, b_de}, 32'd1);
    chk("lsb_word", b_pdata, 32'h04030201);
    drive(0, 0, 0, 8'h00);
    chk("lsb_eol", {31'd0, b_eol}, 32'd1);
    chk("lsb_lw",  {20'd0, b_lw}, 32'd1);
    drive(0, 0, 0, 8'h00);

    // Partial line, RATIO=3
    drive(0, 0, 1, 8'hA1);
    drive(0, 0, 1, 8'hA2);
    drive(0, 0, 1, 8'hA3);
    drive(0, 0, 1, 8'hA4);
    chk("part_w0_de", {31'd0, c_de}, 32'd1);
    chk("part_w0",    {8'd0, c_pdata}, 32'h00A1A2A3);
    drive(0, 0, 0, 8'h00);
    chk("part_hold_de", {31'd0, c_de}, 32'd0);
    drive(0, 0, 0, 8'h00);
    chk("part_eol", {31'd0, c_eol}, 32'd1);
`ifdef CMOS_PACK_FLUSH_EN
    chk("part_flush_de", {31'd0, c_de}, 32'd1);
    chk("part_flush",    {8'd0, c_pdata}, 32'h00A40000);
    chk("part_lw",       {20'd0, c_lw}, 32'd2);
`else
    chk("part_flush_de", {31'd0, c_de}, 32'd0);
    chk("part_flush",    {8'd0, c_pdata}, 32'd0);
    chk("part_lw",       {20'd0, c_lw}, 32'd1);
`endif
    drive(0, 0, 0, 8'h00);

    // Realignment across a one-cycle gap, RATIO=2
    drive(0, 0, 1, 8'h10);
    drive(0, 0, 1, 8'h20);
    drive(0, 0, 1, 8'h30);
    chk("realign_w0", {15'd0, a_de, a_pdata}, 32'h11020);
    drive(0, 0, 0, 8'h00);
    chk("realign_gap_de", {31'd0, a_de}, 32'd0);
    drive(0, 0, 1, 8'h40);
    chk("realign_eol", {31'd0, a_eol}, 32'd1);
`ifdef CMOS_PACK_FLUSH_EN
    chk("realign_flush", {15'd0, a_de, a_pdata}, 32'h13000);
    chk("realign_lw",    {20'd0, a_lw}, 32'd2);
`else
    chk("realign_flush", {15'd0, a_de, a_pdata}, 32'h00000);
    chk("realign_lw",    {20'd0, a_lw}, 32'd1);
`endif
    drive(0, 0, 1, 8'h50);
    chk("realign_mid", {15'd0, a_de, a_pdata}, 32'h00000);
    drive(0, 0, 0, 8'h00);
    chk("realign_w1", {15'd0, a_de, a_pdata}, 32'h14050);
    drive(0, 0, 0, 8'h00);
    chk("realign_eol2", {31'd0, a_eol}, 32'd1);
    chk("realign_lw2",  {20'd0, a_lw}, 32'd1);
    drive(0, 0, 0, 8'h00);

    // Frame sync with priority over de_i, mid-group
    drive(0, 0, 1, 8'hB1);
    drive(0, 1, 1, 8'hB2);
    chk("vs_de0", {31'd0, a_de}, 32'd0);
    drive(0, 1, 1, 8'hB3);
    chk("vs_de1",  {31'd0, a_de}, 32'd0);
    chk("vs_eol1", {31'd0, a_eol}, 32'd0);
    drive(0, 0, 1, 8'hC1);
    chk("vs_de2",  {31'd0, a_de}, 32'd0);
    chk("vs_eol2", {31'd0, a_eol}, 32'd0);
    chk("vs_lw",   {20'd0, a_lw}, 32'd1);
    drive(0, 0, 1, 8'hC2);
    chk("vs_de3", {31'd0, a_de}, 32'd0);
    drive(0, 0, 0, 8'h00);
    chk("vs_word", {15'd0, a_de, a_pdata}, 32'h1C1C2);
    drive(0, 0, 0, 8'h00);
    chk("vs_eol", {31'd0, a_eol}, 32'd1);
    chk("vs_lw2", {20'd0, a_lw}, 32'd1);
    drive(0, 0, 0, 8'h00);

    // Reset mid-line
    drive(0, 0, 1, 8'h77);
    drive(1, 0, 1, 8'h88);
    chk("rstml_de",  {31'd0, a_de}, 32'd0);
    chk("rstml_eol", {31'd0, a_eol}, 32'd0);
    chk("rstml_lw",  {20'd0, a_lw}, 32'd0);
    chk("rstml_pd",  {16'd0, a_pdata}, 32'd0);
    drive(0, 0, 1, 8'h55);
    chk("rstml_noeol", {31'd0, a_eol}, 32'd0);
    chk("rstml_node",  {31'd0, a_de}, 32'd0);
    drive(0, 0, 1, 8'h66);
    chk("rstml_mid", {31'd0, a_de}, 32'd0);
    drive(0, 0, 0, 8'h00);
    chk("rstml_word", {15'd0, a_de, a_pdata}, 32'h15566);
    drive(0, 0, 0, 8'h00);
    chk("rstml_eol2", {31'd0, a_eol}, 32'd1);
    chk("rstml_lw2",  {20'd0, a_lw}, 32'd1);
    drive(0, 0, 0, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/cmos_pixel_pack.md
# cmos_pixel_pack

Parametrised sensor-side pixel packer. It collects `RATIO` consecutive `IN_W`-bit beats from a CMOS parallel port into one `IN_W*RATIO`-bit word. Slot order is selectable, and the packer realigns on every line and frame. Optionally it flushes a zero-padded partial word at end of line. It sits directly behind the sensor input register, in the `pclk` domain, ahead of the line buffer / async FIFO.

## Interface
Parameters:
- `IN_W`, 8, width of one input beat (1..16)
- `RATIO`, 2, beats per output word (1..8)
- `MSB_FIRST`, 1, 1: first beat of a group in the most significant slot; 0: first beat in the least significant slot

Ports:
- `pclk`  in  1  pixel clock; the only clock
- `rst`  in  1  reset; synchronous and active-high
- `vsync_i`  in  1  frame sync; level-high clears alignment
- `de_i`  in  1  input data valid / line active
- `pdata_i`  in  `IN_W`  input beat
- `pdata_o`  out  `IN_W*RATIO`  packed word; zero whenever `de_o`=0
- `de_o`  out  1  packed-word valid, one cycle per word
- `eol_o`  out  1  one-cycle end-of-line pulse
- `line_words_o`  out  12  words emitted in the last completed line

## Operation
- Beat counter `bcnt`:
  - width `max(1,$clog2(RATIO))`.
  - Increments on each cycle with `de_i`=1 and `vsync_i`=0.
  - Wraps to 0 after beat `RATIO-1`.
- Slot placement for beat k of a group (k=0..RATIO-1):
  - `MSB_FIRST`=1: bits `[(RATIO-k)*IN_W-1 -: IN_W]`.
  - `MSB_FIRST`=0: bits `[k*IN_W +: IN_W]`.
- Word completion: the beat with `bcnt`=RATIO-1 completes a word. The assembled word is presented on `pdata_o` with `de_o`=1 for exactly one cycle.
- `RATIO`=1: every beat is a word; the block is a 1-cycle registered pass-through.
- Line end:
  - Defined as `de_i` sampled 0 in the cycle after it was sampled 1. Any gap in `de_i`, including a single-cycle gap, is a line end.
  - `bcnt` returns to 0 at line end.
  - The next `de_i`=1 beat is always slot 0.
- `eol_o` pulses for one cycle, in the cycle after the first `de_i`=0 sample.
- `line_words_o`:
  - An internal word counter counts `de_o` pulses in the current line, saturating at 4095.
  - At line end it is copied to `line_words_o`, in the same cycle that `eol_o` is high.
  - The internal counter then clears.
  - `line_words_o` holds its value until the next line end.
- Frame sync: `vsync_i`=1 forces `bcnt`=0, clears the internal word counter, and blocks `de_o`.
  - `de_i` beats are ignored while `vsync_i`=1.
  - `vsync_i` has priority over a simultaneous `de_i`.
  - A line cut short by `vsync_i` produces no `eol_o` and no flush; `line_words_o` is unchanged.
- Reset: all outputs are 0, `bcnt`=0, internal counters are 0, and the partial accumulator is cleared. Reset applied mid-line drops the partial word without producing `eol_o`. After reset is released, the first `de_i` beat is slot 0.

## Timing
- Latency: `de_o`/`pdata_o` rise one `pclk` after the edge that samples the completing beat.
- Throughput: one word per `RATIO` beats. No back-pressure; the downstream consumer must accept every `de_o` pulse.
- Minimum `de_o` spacing is `RATIO` cycles; with `RATIO`=1, `de_o` may be high on consecutive cycles.
- `eol_o`, flush word, and `line_words_o` update all share the same cycle: one cycle after `de_i` is first sampled 0.
- A completed word and `eol_o` never coincide except through a flush. A full word completed on the last beat appears one cycle before `eol_o`.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- Macro: `CMOS_PACK_FLUSH_EN`.
- Defined:
  - At line end with `bcnt`≠0, the partial word is emitted with `de_o`=1, coincident with `eol_o`.
  - Filled slots hold their beats; unfilled slots are 0.
  - The flushed word counts toward `line_words_o`.
- Undefined:
  - Partial beats are discarded, and `de_o`=0 during `eol_o`.
  - `line_words_o` counts full words only.

## Test plan
- Basic 8→16 (`IN_W`=8, `RATIO`=2, `MSB_FIRST`=1): `de_i` high 4 cycles with 0x11,0x22,0x33,0x44 → `de_o` pulses with 0x1122 then 0x3344, 2 cycles apart; `eol_o` 2 cycles after last beat; `line_words_o`=2.
- LSB-first (`RATIO`=4, `MSB_FIRST`=0): beats 0x01,0x02,0x03,0x04 → single word 0x04030201, one cycle after beat 0x04.
- Partial line (`RATIO`=3): beats 0xA1..0xA4, then `de_i`=0.
  - With `CMOS_PACK_FLUSH_EN`: words 0xA1A2A3, then 0xA40000 coincident with `eol_o`; `line_words_o`=2.
  - Without the macro: only 0xA1A2A3; `line_words_o`=1.
- Realignment: `RATIO`=2, beats 0x10,0x20,0x30, one-cycle gap, then 0x40,0x50 → words 0x1020 and 0x4050; `eol_o` after the gap.
  - With flush: 0x3000 at the gap.
  - Without flush: 0x3040 must never appear.
- Frame sync priority: `vsync_i` and `de_i` both high for 2 beats mid-group, then `de_i` only with 0xC1,0xC2 → no `de_o` during `vsync_i`, no `eol_o`, first word 0xC1C2.
- Reset mid-line: `rst` for 1 cycle after 1 of 2 beats → all outputs 0 the next cycle, no flush, no `eol_o`; subsequent beats 0x55,0x66 → 0x5566.
